rotate_angle_gen: RTL and testbench
===================================

Name: rotate_angle_gen

Overview:
- Upstream companion of the image rotate stage; produces the sin_theta/cos_theta pair that rotate consumes.
- Converts an unsigned angle register (full circle = 2^ANGLE_WIDTH counts) into signed sine/cosine using an iterative CORDIC.
- Snoops the image stream on img-domain dvi/dtypei so new coefficients commit only between frames. Rotate never sees a coefficient change mid-frame.

Parameters:
- ANGLE_WIDTH, 10, angle bits; 0..2^ANGLE_WIDTH-1 maps to 0..2π.
- OUT_WIDTH, 12, signed width of sin/cos; 1.0 = 2^(OUT_WIDTH-2) (1024 at default).
- ITERATIONS, 12, CORDIC micro-rotations (1..16).
- GUARD, 4, extra LSBs on internal x/y/z datapath.

Ports:
- clk  in  1  pipeline clock (same clock as rotate).
- reset  in  1  asynchronous, active-high.
- enable  in  1  0 = hold outputs, ignore triggers.
- angle  in  ANGLE_WIDTH  requested angle (DI register).
- load  in  1  single-cycle pulse: compute now, commit at the next safe point.
- dvi  in  1  stream data valid.
- dtypei  in  `DTYPE_WIDTH  stream data type (dtypes.v codes).
- busy  out  1  CORDIC running.
- pending  out  1  result computed, waiting for frame end.
- updated  out  1  one-cycle pulse when sin/cos change.
- sin_theta  out  OUT_WIDTH  signed sine.
- cos_theta  out  OUT_WIDTH  signed cosine.

Behaviour:
- Reset values: busy=0, pending=0, updated=0, sin_theta=0, cos_theta=2^(OUT_WIDTH-2), in_frame=0. All FSM state is cleared.
- in_frame flag:
  - Set on dvi and dtypei == `DTYPE_FRAME_START.
  - Cleared on dvi and dtypei == `DTYPE_FRAME_END.
  - Tracked regardless of enable.
- Trigger: the cycle after the trigger event, the FSM leaves IDLE. A trigger event is either of:
  - enable and load; or
  - enable and frame-end beat and latched angle != angle.
- FSM states: IDLE -> INIT -> ITER -> DONE -> IDLE.
  - INIT (1 cycle): latch angle.
    - Quadrant q = angle[MSB:MSB-1].
    - z = remaining ANGLE_WIDTH-2 bits, left-aligned with GUARD zeros.
    - (x,y) = (K,0) rotated by q*90°, where K = 0.607253*2^(OUT_WIDTH-2+GUARD) rounded.
  - ITER: i counts 0..ITERATIONS-1.
    - d = +1 if z >= 0, else -1.
    - x -= d*(y>>>i); y += d*(x>>>i); z -= d*atan_tbl[i].
    - Arithmetic shifts; both updates use the pre-iteration x,y.
  - DONE (1 cycle): result = x,y truncated by GUARD bits and saturated to ±(2^(OUT_WIDTH-1)-1).
    - If !in_frame: commit to cos/sin and pulse updated.
    - Else: store in a holding register and set pending.
- busy is high in INIT, ITER and DONE. Latency from trigger to busy low is ITERATIONS+2 cycles.
- Pending commit: on a frame-end beat with pending=1:
  - sin/cos update the next cycle, updated pulses, pending clears.
- Triggers while busy are ignored. A load while pending restarts the CORDIC with the new angle and the pending result is discarded.
- Commit and trigger in the same frame-end beat: the pending result commits and the new calc starts. Both happen.
- enable=0: the running calc finishes. pending still commits at frame end. No new triggers are accepted.
- Reset mid-calc: abort immediately and return to reset values.

Optional Feature:
- ROTATE_ANGLE_GEN_ROUND_EN defined: the DONE stage rounds half-up (adds 2^(GUARD-1) before the shift) before saturating.
- Undefined: plain truncation. Max error is ±2 LSB without the macro and ±1 LSB with it.

Decomposition:
- Shared package rotate_pkg holds:
  - atan_tbl constant: atan(2^-i) in angle counts scaled by 2^GUARD, 16 entries.
  - CORDIC gain constant.
  - FSM state encodings.
- One natural sub-module: rotate_cordic_step, a combinational single micro-rotation (x, y, z, i in; x, y, z out). The FSM and commit logic stay in the top.

Test Plan:
- angle=0, load, out of frame -> after 14 cycles cos=1024±2, sin=0±2, updated pulse.
- angle=256 (90°) -> sin=1024±2, cos=0±2. angle=512 -> cos=-1024±2, sin=0±2.
- angle=128 (45°) -> sin=cos=724±2. angle=896 (315°) -> cos=724±2, sin=-724±2.
- load during a frame (FRAME_START seen): outputs unchanged and pending=1 until the FRAME_END beat, then commit next cycle.
- Angle change with no load: update happens only on FRAME_END. A second load during busy is ignored (busy stays a single 14-cycle window).
- Assert reset at ITER i=5 -> outputs return to cos=1024, sin=0, busy=0 asynchronously. No updated pulse follows.

Source files
------------

// File: rtl/rotate_pkg.sv
// rtl/rotate_pkg.sv - shared CORDIC tables, gain, FSM encoding and stream type codes
// for rotate_angle_gen and rotate_cordic_step.
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 4
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START 4'h1
`endif
`ifndef DTYPE_FRAME_END
`define DTYPE_FRAME_END 4'h2
`endif

package rotate_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_ITER = 2'd2,
    ST_DONE = 2'd3
  } cordic_state_t;

  // atan(2^-i) with a full circle of 2^32 counts; rescaled to the build's z width on use
  localparam logic [31:0] ATAN_TBL [16] = '{
    32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
    32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
    32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
    32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D
  };

  // 0.607253 in Q31
  localparam logic [31:0] CORDIC_GAIN_Q31 = 32'd1304065888;

  function automatic logic [31:0] atan_scaled(input logic [3:0] idx, input int zbits);
    logic [31:0] v;
    v = ATAN_TBL[idx];
    return (v + (32'd1 << (31 - zbits))) >> (32 - zbits);
  endfunction

  function automatic logic [31:0] gain_scaled(input int frac_bits);
    return (CORDIC_GAIN_Q31 + (32'd1 << (30 - frac_bits))) >> (31 - frac_bits);
  endfunction

endpackage

// File: rtl/rotate_cordic_step.sv
// rtl/rotate_cordic_step.sv - one combinational CORDIC micro-rotation in rotation mode;
// z holds angle counts with a full circle of 2^ZW.
module rotate_cordic_step
  import rotate_pkg::*;
#(
  parameter int XW = 17,
  parameter int ZW = 14
) (
  input  logic signed [XW-1:0] i_x,
  input  logic signed [XW-1:0] i_y,
  input  logic signed [ZW-1:0] i_z,
  input  logic [3:0]           i_i,
  output logic signed [XW-1:0] o_x,
  output logic signed [XW-1:0] o_y,
  output logic signed [ZW-1:0] o_z
);

  logic signed [XW-1:0] w_xs;
  logic signed [XW-1:0] w_ys;
  logic signed [ZW-1:0] w_atan;

  assign w_xs   = i_x >>> i_i;
  assign w_ys   = i_y >>> i_i;
  assign w_atan = ZW'(atan_scaled(i_i, ZW));

  always_comb begin
    if (!i_z[ZW-1]) begin
      o_x = i_x - w_ys;
      o_y = i_y + w_xs;
      o_z = i_z - w_atan;
    end else begin
      o_x = i_x + w_ys;
      o_y = i_y - w_xs;
      o_z = i_z + w_atan;
    end
  end

endmodule

// File: rtl/rotate_angle_gen.sv
// rtl/rotate_angle_gen.sv - iterative CORDIC sin/cos generator that commits only between frames.
// ROTATE_ANGLE_GEN_ROUND_EN selects round-half-up instead of truncation in the DONE stage.
module rotate_angle_gen
  import rotate_pkg::*;
#(
  parameter int ANGLE_WIDTH = 10,
  parameter int OUT_WIDTH   = 12,
  parameter int ITERATIONS  = 12,
  parameter int GUARD       = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [ANGLE_WIDTH-1:0]      angle,
  input  logic                        load,
  input  logic                        dvi,
  input  logic [`DTYPE_WIDTH-1:0]     dtypei,
  output logic                        busy,
  output logic                        pending,
  output logic                        updated,
  output logic signed [OUT_WIDTH-1:0] sin_theta,
  output logic signed [OUT_WIDTH-1:0] cos_theta
);

  localparam int XW = OUT_WIDTH + GUARD + 1;
  localparam int ZW = ANGLE_WIDTH + GUARD;
  localparam logic signed [XW-1:0]        K_INIT    = XW'(gain_scaled(OUT_WIDTH - 2 + GUARD));
  localparam logic signed [OUT_WIDTH-1:0] COS_RESET = OUT_WIDTH'(2 ** (OUT_WIDTH - 2));
  localparam logic signed [XW:0]          SAT_HI    = (XW+1)'(2 ** (OUT_WIDTH - 1) - 1);
  localparam logic signed [XW:0]          SAT_LO    = -SAT_HI;
  localparam logic signed [XW:0]          RND_HALF  = (XW+1)'(2 ** (GUARD - 1));
  localparam logic [3:0]                  ITER_LAST = 4'(ITERATIONS - 1);

  cordic_state_t r_state, w_next_state;
  logic [ANGLE_WIDTH-1:0]      r_angle;
  logic signed [XW-1:0]        r_x, r_y, w_x0, w_y0, w_x_step, w_y_step;
  logic signed [ZW-1:0]        r_z, w_z0, w_z_step;
  logic [3:0]                  r_iter;
  logic                        r_in_frame, r_pending, r_updated;
  logic signed [OUT_WIDTH-1:0] r_sin, r_cos, r_hold_sin, r_hold_cos, w_res_sin, w_res_cos;
  logic                        w_frame_start, w_frame_end, w_trigger;

  function automatic logic signed [OUT_WIDTH-1:0] to_out(input logic signed [XW-1:0] v);
    logic signed [XW:0] t;
    t = {v[XW-1], v};
`ifdef ROTATE_ANGLE_GEN_ROUND_EN
    t = t + RND_HALF;
`endif
    t = t >>> GUARD;
    if (t > SAT_HI)      return SAT_HI[OUT_WIDTH-1:0];
    else if (t < SAT_LO) return SAT_LO[OUT_WIDTH-1:0];
    else                 return t[OUT_WIDTH-1:0];
  endfunction

  assign w_frame_start = dvi && (dtypei == `DTYPE_FRAME_START);
  assign w_frame_end   = dvi && (dtypei == `DTYPE_FRAME_END);
  assign w_trigger     = enable && (r_state == ST_IDLE) &&
                         (load || (w_frame_end && (r_angle != angle)));

  // Start vector is (K,0) pre-rotated into the quadrant; z covers the remaining 0..90 degrees.
  always_comb begin
    w_x0 = K_INIT;
    w_y0 = '0;
    case (angle[ANGLE_WIDTH-1 -: 2])
      2'd1:    begin w_x0 = '0;      w_y0 = K_INIT;  end
      2'd2:    begin w_x0 = -K_INIT; w_y0 = '0;      end
      2'd3:    begin w_x0 = '0;      w_y0 = -K_INIT; end
      default: begin w_x0 = K_INIT;  w_y0 = '0;      end
    endcase
  end

  assign w_z0      = ZW'({angle[ANGLE_WIDTH-3:0], {GUARD{1'b0}}});
  assign w_res_sin = to_out(r_y);
  assign w_res_cos = to_out(r_x);

  rotate_cordic_step #(.XW(XW), .ZW(ZW)) u_step (
    .i_x(r_x), .i_y(r_y), .i_z(r_z), .i_i(r_iter),
    .o_x(w_x_step), .o_y(w_y_step), .o_z(w_z_step)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_trigger) w_next_state = ST_INIT;
      ST_INIT: w_next_state = ST_ITER;
      ST_ITER: if (r_iter == ITER_LAST) w_next_state = ST_DONE;
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_angle    <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_z        <= '0;
      r_iter     <= '0;
      r_in_frame <= 1'b0;
      r_pending  <= 1'b0;
      r_updated  <= 1'b0;
      r_sin      <= '0;
      r_cos      <= COS_RESET;
      r_hold_sin <= '0;
      r_hold_cos <= '0;
    end else begin
      r_updated <= 1'b0;
      if (w_frame_start)    r_in_frame <= 1'b1;
      else if (w_frame_end) r_in_frame <= 1'b0;

      case (r_state)
        ST_INIT: begin
          r_angle <= angle;
          r_x     <= w_x0;
          r_y     <= w_y0;
          r_z     <= w_z0;
          r_iter  <= '0;
        end
        ST_ITER: begin
          r_x    <= w_x_step;
          r_y    <= w_y_step;
          r_z    <= w_z_step;
          r_iter <= r_iter + 4'd1;
        end
        default: ;
      endcase

      // A held result commits on the frame-end beat even if that beat also starts a new calc.
      if (w_frame_end && r_pending) begin
        r_cos     <= r_hold_cos;
        r_sin     <= r_hold_sin;
        r_updated <= 1'b1;
        r_pending <= 1'b0;
      end else if (w_trigger) begin
        r_pending <= 1'b0;
      end

      if (r_state == ST_DONE) begin
        if (!r_in_frame || w_frame_end) begin
          r_cos     <= w_res_cos;
          r_sin     <= w_res_sin;
          r_updated <= 1'b1;
        end else begin
          r_hold_cos <= w_res_cos;
          r_hold_sin <= w_res_sin;
          r_pending  <= 1'b1;
        end
      end
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign pending   = r_pending;
  assign updated   = r_updated;
  assign sin_theta = r_sin;
  assign cos_theta = r_cos;

endmodule

// File: tb/tb_rotate_angle_gen.sv
// tb/tb_rotate_angle_gen.sv - scoreboard bench for rotate_angle_gen against a real-math sin/cos model.
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 4
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START 4'h1
`endif
`ifndef DTYPE_FRAME_END
`define DTYPE_FRAME_END 4'h2
`endif

module tb_rotate_angle_gen;

  localparam int  AW      = 10;
  localparam int  OW      = 12;
  localparam int  ITERS   = 12;
  localparam int  ONE     = 1 << (OW - 2);
  localparam int  WINDOW  = ITERS + 2;
  localparam int  TOL_DIR = 2;
  localparam int  TOL_RND = 3;
  localparam real PI      = 3.14159265358979;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b1;
  logic load = 1'b0;
  logic dvi = 1'b0;
  logic [AW-1:0] angle = '0;
  logic [`DTYPE_WIDTH-1:0] dtypei = '0;
  logic busy, pending, updated;
  logic signed [OW-1:0] sin_theta, cos_theta;

  typedef struct {
    int s;
    int c;
    int tol;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail = 0;
  int   last_s = 0;
  int   last_c = ONE;
  int   last_tol = 0;

  rotate_angle_gen dut (
    .clk(clk), .reset(reset), .enable(enable), .angle(angle), .load(load),
    .dvi(dvi), .dtypei(dtypei), .busy(busy), .pending(pending), .updated(updated),
    .sin_theta(sin_theta), .cos_theta(cos_theta)
  );

  always #5 clk = ~clk;

  function automatic int model_sin(input int a);
    real th;
    th = 2.0 * PI * real'(a) / real'(1 << AW);
    return int'($floor(real'(ONE) * $sin(th) + 0.5));
  endfunction

  function automatic int model_cos(input int a);
    real th;
    th = 2.0 * PI * real'(a) / real'(1 << AW);
    return int'($floor(real'(ONE) * $cos(th) + 0.5));
  endfunction

  task automatic check(input string name, input int act, input int exp, input int tol);
    int d;
    n_checks++;
    d = act - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", name, act, exp, tol);
    end
  endtask

  task automatic push_exp(input int a, input int tol);
    exp_t e;
    e.s = model_sin(a);
    e.c = model_cos(a);
    e.tol = tol;
    sb.push_back(e);
    last_s = e.s;
    last_c = e.c;
    last_tol = tol;
  endtask

  task automatic do_load(input int a);
    @(posedge clk);
    #1;
    angle = AW'(a);
    load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  task automatic beat(input logic [`DTYPE_WIDTH-1:0] t);
    @(posedge clk);
    #1;
    dvi = 1'b1;
    dtypei = t;
    @(posedge clk);
    #1;
    dvi = 1'b0;
    dtypei = '0;
  endtask

  // Counts busy cycles after a trigger; optionally pulses a second load at busy cycle 'inject'.
  task automatic run_window(input string name, input int inject, input int inj_angle);
    int n;
    logic [AW-1:0] keep;
    n = 0;
    keep = angle;
    @(negedge clk);
    while (busy && n < 40) begin
      n++;
      if (n == inject) begin
        angle = AW'(inj_angle);
        load = 1'b1;
      end else if (n == inject + 1) begin
        load = 1'b0;
        angle = keep;
      end
      @(negedge clk);
    end
    check(name, n, WINDOW, 0);
  endtask

  always @(negedge clk) begin
    if (!reset && updated) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_update: got updated=1 expected no commit (sin %0d cos %0d)",
                 sin_theta, cos_theta);
      end else begin
        mon_e = sb.pop_front();
        check("commit_sin", int'(sin_theta), mon_e.s, mon_e.tol);
        check("commit_cos", int'(cos_theta), mon_e.c, mon_e.tol);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  int dir_angles [5] = '{0, 256, 512, 128, 896};

  initial begin
    int a, b;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", int'(busy), 0, 0);
    check("reset_pending", int'(pending), 0, 0);
    check("reset_updated", int'(updated), 0, 0);
    check("reset_sin", int'(sin_theta), 0, 0);
    check("reset_cos", int'(cos_theta), ONE, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    foreach (dir_angles[k]) begin
      push_exp(dir_angles[k], TOL_DIR);
      do_load(dir_angles[k]);
      run_window("dir_busy_cycles", 0, 0);
    end

    push_exp(300, TOL_RND);
    do_load(300);
    run_window("busy_ignores_load", 3, 700);

    beat(`DTYPE_FRAME_START);
    do_load(600);
    run_window("inframe_busy_cycles", 0, 0);
    check("inframe_pending", int'(pending), 1, 0);
    check("inframe_hold_cos", int'(cos_theta), last_c, last_tol);
    check("inframe_hold_sin", int'(sin_theta), last_s, last_tol);
    do_load(40);
    run_window("restart_busy_cycles", 0, 0);
    check("restart_pending", int'(pending), 1, 0);
    push_exp(40, TOL_RND);
    beat(`DTYPE_FRAME_END);
    @(negedge clk);
    check("frame_end_pending_clear", int'(pending), 0, 0);

    beat(`DTYPE_FRAME_START);
    do_load(170);
    run_window("combo_first_busy", 0, 0);
    angle = AW'(777);
    push_exp(170, TOL_RND);
    push_exp(777, TOL_RND);
    beat(`DTYPE_FRAME_END);
    run_window("combo_second_busy", 0, 0);

    beat(`DTYPE_FRAME_START);
    angle = AW'(450);
    repeat (20) @(negedge clk);
    check("angle_change_no_trigger", int'(busy), 0, 0);
    check("angle_change_no_pending", int'(pending), 0, 0);
    push_exp(450, TOL_RND);
    beat(`DTYPE_FRAME_END);
    run_window("angle_change_busy", 0, 0);

    enable = 1'b0;
    do_load(90);
    repeat (3) @(negedge clk);
    check("disabled_load_ignored", int'(busy), 0, 0);
    angle = AW'(450);
    enable = 1'b1;

    for (int r = 0; r < 8; r++) begin
      a = int'($urandom_range(0, (1 << AW) - 1));
      b = int'($urandom_range(0, 1));
      if (b == 1) begin
        beat(`DTYPE_FRAME_START);
        do_load(a);
        run_window("rnd_inframe_busy", 0, 0);
        check("rnd_inframe_pending", int'(pending), 1, 0);
        push_exp(a, TOL_RND);
        beat(`DTYPE_FRAME_END);
        @(negedge clk);
      end else begin
        push_exp(a, TOL_RND);
        do_load(a);
        run_window("rnd_busy", 0, 0);
      end
    end

    do_load(333);
    repeat (6) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("abort_busy", int'(busy), 0, 0);
    check("abort_pending", int'(pending), 0, 0);
    check("abort_sin", int'(sin_theta), 0, 0);
    check("abort_cos", int'(cos_theta), ONE, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    angle = '0;
    repeat (20) @(negedge clk);
    check("abort_no_restart", int'(busy), 0, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
